// File: rtl/yutorina_bus_master_if.sv
// Master-side bus sequencer: turns a one-cycle client request into a
// request/grant/strobe/ready bus transaction, with a watchdog that aborts
// accesses whose slave never answers. All outputs are registered.
module yutorina_bus_master_if #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              m_req_,
    input  logic              m_grnt_,
    output logic              m_as_,
    output logic              m_rw,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wr_data,
    input  logic [DATA_W-1:0] s_rd_data,
    input  logic              s_rdy_
);

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, WAIT_RDY} state_t;

    // Client request captured at acceptance, replayed onto the bus at grant.
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
    } req_t;

    localparam logic [15:0] TO = 16'(TIMEOUT);

    state_t            state, state_nxt;
    req_t              lat, lat_nxt;
    logic [15:0]       wd, wd_nxt;
    logic              req_n_nxt, as_n_nxt, rw_nxt, busy_nxt, done_nxt, err_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt, rd_nxt;
    logic              rel;

    // Next-state and next-output computation; every register has a default.
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat;
        wd_nxt    = wd;
        req_n_nxt = m_req_;
        as_n_nxt  = 1'b1;          // strobe is low for the ACCESS cycle only
        rw_nxt    = m_rw;
        addr_nxt  = m_addr;
        wdata_nxt = m_wr_data;
        rd_nxt    = cpu_rd_data;
        busy_nxt  = cpu_busy;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        rel       = 1'b0;

        // busy covers the done/err cycle itself and drops right after it
        if (cpu_done || cpu_err)
            busy_nxt = 1'b0;

        case (state)
            IDLE: begin
                // busy still high on the done/err cycle, so a request there is dropped
                if (cpu_req && !cpu_busy) begin
                    lat_nxt   = '{rw: cpu_rw, addr: cpu_addr, wr_data: cpu_wr_data};
                    req_n_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (!m_grnt_) begin
                    as_n_nxt  = 1'b0;
                    rw_nxt    = lat.rw;
                    addr_nxt  = lat.addr;
                    wdata_nxt = lat.wr_data;
                    wd_nxt    = '0;
                    state_nxt = ACCESS;
                end
            end
            ACCESS, WAIT_RDY: begin
                // ready wins over the timeout when both land on the same cycle
                if (!s_rdy_) begin
                    done_nxt = 1'b1;
                    if (m_rw)
                        rd_nxt = s_rd_data;
                    rel = 1'b1;
                end else if (state == WAIT_RDY && wd == TO) begin
                    err_nxt = 1'b1;
                    rel     = 1'b1;
                end else begin
                    wd_nxt    = wd + 16'd1;
                    state_nxt = WAIT_RDY;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Releasing the bus zeroes our drive so the OR-muxed bus sees only the owner.
        if (rel) begin
            req_n_nxt = 1'b1;
            as_n_nxt  = 1'b1;
            rw_nxt    = 1'b1;
            addr_nxt  = '0;
            wdata_nxt = '0;
            state_nxt = IDLE;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat         <= '0;
            wd          <= '0;
            m_req_      <= 1'b1;
            m_as_       <= 1'b1;
            m_rw        <= 1'b1;
            m_addr      <= '0;
            m_wr_data   <= '0;
            cpu_rd_data <= '0;
            cpu_busy    <= 1'b0;
            cpu_done    <= 1'b0;
            cpu_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            lat         <= lat_nxt;
            wd          <= wd_nxt;
            m_req_      <= req_n_nxt;
            m_as_       <= as_n_nxt;
            m_rw        <= rw_nxt;
            m_addr      <= addr_nxt;
            m_wr_data   <= wdata_nxt;
            cpu_rd_data <= rd_nxt;
            cpu_busy    <= busy_nxt;
            cpu_done    <= done_nxt;
            cpu_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_yutorina_bus_master_if.sv
// Directed bench for the bus master sequencer. Cycle c means the interval
// after the c-th edge of a scenario; inputs set in cycle c are sampled at its
// closing edge, outputs read in cycle c are the registered values of that cycle.
module tb_yutorina_bus_master_if;

    logic        clk, rst;
    logic        req0, rw0, busy0, done0, err0, mreq0_, gnt0_, as0_, mrw0, srdy0_;
    logic [29:0] addr0, maddr0;
    logic [31:0] wdat0, rdat0, mwdat0, srd0;
    logic        req1, rw1, busy1, done1, err1, mreq1_, gnt1_, as1_, mrw1, srdy1_;
    logic [29:0] addr1, maddr1;
    logic [31:0] wdat1, rdat1, mwdat1, srd1;

    logic        arb_en, ag0_, ag1_, last_own, dg0_, ds0_;
    logic [31:0] dsrd0;
    int          checks = 0, errors = 0;

    // Directed mode: bench drives grant/slave of master 0. Arbiter mode: a
    // round-robin arbiter model grants, and zero-wait slaves answer the strobe.
    assign gnt0_  = arb_en ? ag0_ : dg0_;
    assign srdy0_ = arb_en ? as0_ : ds0_;
    assign srd0   = arb_en ? ({2'b00, maddr0} ^ 32'hA5A5_0000) : dsrd0;
    assign gnt1_  = ag1_;
    assign srdy1_ = arb_en ? as1_ : 1'b1;
    assign srd1   = {2'b00, maddr1} ^ 32'hA5A5_0000;

    yutorina_bus_master_if #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(4)) u0 (
        .clk(clk), .rst(rst), .cpu_req(req0), .cpu_rw(rw0), .cpu_addr(addr0),
        .cpu_wr_data(wdat0), .cpu_rd_data(rdat0), .cpu_busy(busy0), .cpu_done(done0),
        .cpu_err(err0), .m_req_(mreq0_), .m_grnt_(gnt0_), .m_as_(as0_), .m_rw(mrw0),
        .m_addr(maddr0), .m_wr_data(mwdat0), .s_rd_data(srd0), .s_rdy_(srdy0_));

    yutorina_bus_master_if #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(255)) u1 (
        .clk(clk), .rst(rst), .cpu_req(req1), .cpu_rw(rw1), .cpu_addr(addr1),
        .cpu_wr_data(wdat1), .cpu_rd_data(rdat1), .cpu_busy(busy1), .cpu_done(done1),
        .cpu_err(err1), .m_req_(mreq1_), .m_grnt_(gnt1_), .m_as_(as1_), .m_rw(mrw1),
        .m_addr(maddr1), .m_wr_data(mwdat1), .s_rd_data(srd1), .s_rdy_(srdy1_));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin arbiter model: registered grant, held while owner keeps m_req_ low.
    always @(posedge clk) begin
        if (!arb_en) begin
            ag0_ <= 1'b1; ag1_ <= 1'b1; last_own <= 1'b1;
        end else if (!(!ag0_ && !mreq0_) && !(!ag1_ && !mreq1_)) begin
            ag0_ <= 1'b1; ag1_ <= 1'b1;
            if (!mreq0_ && (last_own || mreq1_)) begin
                ag0_ <= 1'b0; last_own <= 1'b0;
            end else if (!mreq1_) begin
                ag1_ <= 1'b0; last_own <= 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; arb_en = 1'b0; dg0_ = 1'b1; ds0_ = 1'b1; dsrd0 = '0;
        req0 = 0; rw0 = 0; addr0 = '0; wdat0 = '0;
        req1 = 0; rw1 = 0; addr1 = '0; wdat1 = '0;
        repeat (3) step();
        checks++;
        if ({mreq0_, as0_, mrw0, maddr0, mwdat0, rdat0, busy0, done0, err0} !==
            {3'b111, 30'h0, 32'h0, 32'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset_u0: got %b%b%b %h %h %h %b%b%b want 111 0 0 0 000",
                     mreq0_, as0_, mrw0, maddr0, mwdat0, rdat0, busy0, done0, err0);
        end
        checks++;
        if ({mreq1_, as1_, mrw1, maddr1, mwdat1, rdat1, busy1, done1, err1} !==
            {3'b111, 30'h0, 32'h0, 32'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset_u1: got %b%b%b %h %h %h want 111 0 0 0",
                     mreq1_, as1_, mrw1, maddr1, mwdat1, rdat1);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({mreq0_, as0_, busy0} !== 3'b110) begin
            errors++;
            $display("FAIL idle_after_reset: got %b%b%b want 110", mreq0_, as0_, busy0);
        end
    endtask

    task automatic test_read_zero_wait();
        int as_n = 0, as_c = -1;
        for (int c = 0; c <= 5; c++) begin
            if (!as0_) begin as_n++; as_c = c; end
            if (c == 1) begin
                checks++;
                if ({mreq0_, as0_, busy0} !== 3'b011) begin
                    errors++;
                    $display("FAIL rd_c1_req: got req_=%b as_=%b busy=%b want 0 1 1", mreq0_, as0_, busy0);
                end
            end
            if (c == 2) begin
                checks++;
                if ({mrw0, maddr0} !== {1'b1, 30'h100}) begin
                    errors++;
                    $display("FAIL rd_c2_bus: got rw=%b addr=%h want 1 100", mrw0, maddr0);
                end
            end
            if (c == 3) begin
                checks++;
                if ({done0, busy0, mreq0_, as0_, maddr0, rdat0} !== {4'b1111, 30'h0, 32'hDEADBEEF}) begin
                    errors++;
                    $display("FAIL rd_c3_done: got done=%b busy=%b req_=%b as_=%b addr=%h rd=%h want 1111 0 deadbeef",
                             done0, busy0, mreq0_, as0_, maddr0, rdat0);
                end
            end
            if (c == 4) begin
                checks++;
                if ({done0, busy0} !== 2'b00) begin
                    errors++;
                    $display("FAIL rd_c4_idle: got done=%b busy=%b want 00", done0, busy0);
                end
            end
            req0 = (c == 0); rw0 = 1'b1; addr0 = 30'h100; wdat0 = 32'h0;
            dg0_ = 1'b0; ds0_ = 1'b0; dsrd0 = 32'hDEADBEEF;
            step();
        end
        checks++;
        if (as_n != 1 || as_c != 2) begin
            errors++;
            $display("FAIL rd_strobe: got %0d strobes last at %0d want 1 at 2", as_n, as_c);
        end
        dg0_ = 1'b1; ds0_ = 1'b1;
    endtask

    task automatic test_write_waits();
        int as_n = 0, as_c = -1, dn_n = 0, dn_c = -1, er_n = 0;
        for (int c = 0; c <= 14; c++) begin
            if (!as0_) begin as_n++; as_c = c; end
            if (done0) begin dn_n++; dn_c = c; end
            if (err0) er_n++;
            if (c >= 1 && c <= 9) begin
                checks++;
                if ({mreq0_, busy0} !== 2'b01) begin
                    errors++;
                    $display("FAIL wr_own_c%0d: got req_=%b busy=%b want 0 1", c, mreq0_, busy0);
                end
            end
            if (c >= 5 && c <= 9) begin
                checks++;
                if ({mrw0, maddr0, mwdat0} !== {1'b0, 30'h2A, 32'h12345678}) begin
                    errors++;
                    $display("FAIL wr_hold_c%0d: got rw=%b addr=%h data=%h want 0 2a 12345678",
                             c, mrw0, maddr0, mwdat0);
                end
            end
            req0 = (c == 0); rw0 = 1'b0; addr0 = 30'h2A; wdat0 = 32'h12345678;
            dg0_ = (c >= 4) ? 1'b0 : 1'b1;
            ds0_ = (c == 9) ? 1'b0 : 1'b1;
            dsrd0 = 32'hBAD0BAD0;
            step();
        end
        checks++;
        if (as_n != 1 || as_c != 5 || dn_n != 1 || dn_c != 10 || er_n != 0) begin
            errors++;
            $display("FAIL wr_seq: got as %0d@%0d done %0d@%0d err %0d want as 1@5 done 1@10 err 0",
                     as_n, as_c, dn_n, dn_c, er_n);
        end
        checks++;
        if (rdat0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_rd_keep: got %h want deadbeef", rdat0);
        end
        dg0_ = 1'b1; ds0_ = 1'b1;
    endtask

    task automatic test_timeout();
        int as_c = -1, er_n = 0, er_c = -1, dn_n = 0;
        for (int c = 0; c <= 12; c++) begin
            if (!as0_) as_c = c;
            if (err0) begin er_n++; er_c = c; end
            if (done0) dn_n++;
            if (c == 7) begin
                checks++;
                if ({mreq0_, as0_, mrw0, maddr0, mwdat0, busy0} !== {3'b111, 30'h0, 32'h0, 1'b1}) begin
                    errors++;
                    $display("FAIL to_release: got req_=%b as_=%b rw=%b addr=%h data=%h busy=%b want 111 0 0 1",
                             mreq0_, as0_, mrw0, maddr0, mwdat0, busy0);
                end
            end
            if (c == 8) begin
                checks++;
                if (busy0 !== 1'b0) begin
                    errors++;
                    $display("FAIL to_busy_drop: got %b want 0", busy0);
                end
            end
            req0 = (c == 0); rw0 = 1'b1; addr0 = 30'h33; wdat0 = 32'hFFFFFFFF;
            dg0_ = 1'b0; ds0_ = 1'b1; dsrd0 = 32'h55555555;
            step();
        end
        checks++;
        if (as_c != 2 || er_n != 1 || er_c != 7 || dn_n != 0) begin
            errors++;
            $display("FAIL to_seq: got as@%0d err %0d@%0d done %0d want as@2 err 1@7 done 0",
                     as_c, er_n, er_c, dn_n);
        end
        checks++;
        if (rdat0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL to_rd_keep: got %h want deadbeef", rdat0);
        end
        dg0_ = 1'b1;
    endtask

    task automatic test_back_to_back();
        int as_n = 0, dn_n = 0, c1 = -1, c2 = -1, d1 = -1, d2 = -1;
        logic [29:0] a1 = '0, a2 = '0;
        for (int c = 0; c <= 10; c++) begin
            if (!as0_) begin
                as_n++;
                if (as_n == 1) begin a1 = maddr0; c1 = c; end else begin a2 = maddr0; c2 = c; end
            end
            if (done0) begin
                dn_n++;
                if (dn_n == 1) d1 = c; else d2 = c;
            end
            if (c == 3) begin
                checks++;
                if (rdat0 !== 32'h11110002) begin
                    errors++;
                    $display("FAIL b2b_rd1: got %h want 11110002", rdat0);
                end
            end
            if (c == 4) begin
                checks++;
                if (busy0 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_busy_gap: got %b want 0", busy0);
                end
            end
            if (c == 5) begin
                checks++;
                if ({busy0, mreq0_} !== 2'b10) begin
                    errors++;
                    $display("FAIL b2b_accept: got busy=%b req_=%b want 1 0", busy0, mreq0_);
                end
            end
            req0  = (c == 0 || c == 1 || c == 3 || c == 4);
            addr0 = (c == 0) ? 30'h10 : (c == 1) ? 30'h20 : (c == 3) ? 30'h30 : 30'h40;
            rw0 = 1'b1; wdat0 = '0; dg0_ = 1'b0; ds0_ = 1'b0;
            dsrd0 = 32'h11110000 + 32'(c);
            step();
        end
        checks++;
        if (as_n != 2 || c1 != 2 || c2 != 6 || a1 !== 30'h10 || a2 !== 30'h40) begin
            errors++;
            $display("FAIL b2b_strobes: got %0d at %0d/%0d addr %h/%h want 2 at 2/6 addr 10/40",
                     as_n, c1, c2, a1, a2);
        end
        checks++;
        if (dn_n != 2 || d1 != 3 || d2 != 7 || rdat0 !== 32'h11110006) begin
            errors++;
            $display("FAIL b2b_done: got %0d at %0d/%0d rd %h want 2 at 3/7 rd 11110006",
                     dn_n, d1, d2, rdat0);
        end
        dg0_ = 1'b1; ds0_ = 1'b1;
    endtask

    task automatic test_reset_mid();
        int dn_n = 0, dn_c = -1, er_n = 0;
        for (int c = 0; c <= 10; c++) begin
            if (done0) begin dn_n++; dn_c = c; end
            if (err0) er_n++;
            if (c == 3) begin
                checks++;
                if ({mreq0_, as0_, mwdat0} !== {2'b01, 32'hCAFE0001}) begin
                    errors++;
                    $display("FAIL rm_wait: got req_=%b as_=%b data=%h want 0 1 cafe0001", mreq0_, as0_, mwdat0);
                end
            end
            if (c == 4) begin
                checks++;
                if ({mreq0_, as0_, mrw0, maddr0, mwdat0, rdat0, busy0, done0, err0} !==
                    {3'b111, 30'h0, 32'h0, 32'h0, 3'b000}) begin
                    errors++;
                    $display("FAIL rm_reset_vals: got %b%b%b %h %h %h %b%b%b want 111 0 0 0 000",
                             mreq0_, as0_, mrw0, maddr0, mwdat0, rdat0, busy0, done0, err0);
                end
            end
            rst  = (c == 3);
            req0 = (c == 0 || c == 5);
            rw0  = (c >= 5);
            addr0 = (c >= 5) ? 30'h9 : 30'h7;
            wdat0 = 32'hCAFE0001;
            dg0_ = 1'b0;
            ds0_ = (c >= 5) ? 1'b0 : 1'b1;
            dsrd0 = 32'h600D600D;
            step();
        end
        checks++;
        if (dn_n != 1 || dn_c != 8 || er_n != 0 || rdat0 !== 32'h600D600D) begin
            errors++;
            $display("FAIL rm_after: got done %0d@%0d err %0d rd %h want done 1@8 err 0 rd 600d600d",
                     dn_n, dn_c, er_n, rdat0);
        end
        dg0_ = 1'b1; ds0_ = 1'b1;
    endtask

    task automatic test_two_masters();
        int as0c = -1, dn0c = -1, as1c = -1, dn1c = -1;
        arb_en = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (!as0_) as0c = c;
            if (done0) dn0c = c;
            if (!as1_) as1c = c;
            if (done1) dn1c = c;
            if (c == 3) begin
                checks++;
                if ({mreq1_, maddr1, mwdat1} !== {1'b0, 30'h0, 32'h0}) begin
                    errors++;
                    $display("FAIL mm_m1_quiet: got req_=%b addr=%h data=%h want 0 0 0", mreq1_, maddr1, mwdat1);
                end
            end
            req0 = (c == 0); rw0 = 1'b1; addr0 = 30'h100; wdat0 = '0;
            req1 = (c == 0); rw1 = 1'b1; addr1 = 30'h200; wdat1 = '0;
            step();
        end
        checks++;
        if (as0c != 3 || dn0c != 4 || as1c != 6 || dn1c != 7) begin
            errors++;
            $display("FAIL mm_order: got m0 as@%0d done@%0d m1 as@%0d done@%0d want 3 4 6 7",
                     as0c, dn0c, as1c, dn1c);
        end
        checks++;
        if (rdat0 !== 32'hA5A50100 || rdat1 !== 32'hA5A50200) begin
            errors++;
            $display("FAIL mm_data: got %h %h want a5a50100 a5a50200", rdat0, rdat1);
        end
        arb_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_waits();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_two_masters();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
